saber_gesture_detector: RTL and testbench

- Upstream neighbour of the per-frame action state machine; turns raw player inputs into its block/lunge/release gesture flags plus a validity strobe.
- Inputs: IR saber-tip centroid samples (position plus blob area, one per video frame) and the physical block button.
- A thrust toward the camera is detected as sustained blob-area growth. Block is a debounced button hold.
- Emits one gesture report per accepted sample.

---
 rtl/saber_gesture_detector_pkg.sv | 33 +++
 rtl/saber_gesture_detector_button_debouncer.sv | 48 ++++
 rtl/saber_gesture_detector.sv | 169 ++++++++++++++++
 tb/tb_saber_gesture_detector.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saber_gesture_detector_pkg.sv
// Shared types and default thresholds for the saber gesture detector.
// Imported by the detector top and its button debouncer.
package saber_gesture_detector_pkg;

  localparam int unsigned AREA_W  = 16;
  localparam int unsigned DELTA_W = AREA_W + 1;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000000;
  localparam int unsigned DEF_LUNGE_AREA_DELTA  = 16;
  localparam int unsigned DEF_LUNGE_FRAMES      = 3;
  localparam int unsigned DEF_MAX_THRUST_FRAMES = 30;
  localparam int unsigned DEF_MIN_AREA          = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLOCKING  = 2'd1,
    THRUSTING = 2'd2
  } gesture_state_t;

  typedef struct packed {
    logic block;
    logic lunge;
    logic rel;
  } gesture_report_t;

  function automatic logic signed [DELTA_W-1:0] area_delta(
    input logic [AREA_W-1:0] cur,
    input logic [AREA_W-1:0] prev
  );
    return $signed({1'b0, cur}) - $signed({1'b0, prev});
  endfunction

endpackage

// File: rtl/saber_gesture_detector_button_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// The level flips after DEBOUNCE_CYCLES consecutive cycles at the new value.
module button_debouncer
  import saber_gesture_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/saber_gesture_detector.sv
// Turns IR blob samples and the block button into block/lunge/release
// reports, two cycles after each accepted sample.
module saber_gesture_detector
  import saber_gesture_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LUNGE_AREA_DELTA  = DEF_LUNGE_AREA_DELTA,
  parameter int unsigned LUNGE_FRAMES      = DEF_LUNGE_FRAMES,
  parameter int unsigned MAX_THRUST_FRAMES = DEF_MAX_THRUST_FRAMES,
  parameter int unsigned MIN_AREA          = DEF_MIN_AREA
) (
  input  logic              clk_pixel_in,
  input  logic              rst_n_in,
  input  logic              block_btn_in,
  input  logic              sample_valid_in,
  input  logic [10:0]       saber_x_in,
  input  logic [9:0]        saber_y_in,
  input  logic [AREA_W-1:0] blob_area_in,
  output logic              block_out,
  output logic              lunge_out,
  output logic              release_out,
  output logic              ir_out_valid
);

  localparam int unsigned SW = $clog2(LUNGE_FRAMES + 1);
  localparam int unsigned TW = $clog2(MAX_THRUST_FRAMES + 1);

  localparam logic [SW-1:0] STREAK_MAX = SW'(LUNGE_FRAMES);
  localparam logic [TW-1:0] THRUST_END = TW'(MAX_THRUST_FRAMES - 1);
  localparam logic [AREA_W-1:0] AREA_MIN = AREA_W'(MIN_AREA);
  localparam logic signed [DELTA_W-1:0] GROW_TH =
    DELTA_W'(LUNGE_AREA_DELTA);

  logic btn_db;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i  (clk_pixel_in),
    .rst_ni (rst_n_in),
    .btn_i  (block_btn_in),
    .level_o(btn_db)
  );

  // Stage 1: area delta against the previous sample
  logic [AREA_W-1:0]         prev_area_q;
  logic                      prev_valid_q;
  logic                      s1_valid_q;
  logic                      s1_lost_q;
  logic signed [DELTA_W-1:0] s1_delta_q;

  logic                      s1_lost_d;
  logic signed [DELTA_W-1:0] s1_delta_d;

  always_comb begin
    s1_lost_d  = blob_area_in < AREA_MIN;
    s1_delta_d = '0;
    if (prev_valid_q && !s1_lost_d) begin
      s1_delta_d = area_delta(blob_area_in, prev_area_q);
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_area_q  <= '0;
      prev_valid_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_lost_q    <= 1'b0;
      s1_delta_q   <= '0;
    end else begin
      s1_valid_q <= sample_valid_in;
      if (sample_valid_in) begin
        prev_area_q  <= blob_area_in;
        prev_valid_q <= !s1_lost_d;
        s1_lost_q    <= s1_lost_d;
        s1_delta_q   <= s1_delta_d;
      end
    end
  end

  // Stage 2: gesture FSM and report registers
  gesture_state_t  state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  gesture_report_t rpt_q, rpt_d;
  logic            vld_q, vld_d;

  logic          growth;
  logic          retract;
  logic [SW-1:0] streak_inc;

  assign growth  = s1_delta_q >= GROW_TH;
  assign retract = s1_delta_q < 0;

  always_comb begin
    streak_inc = streak_q;
    if (streak_q != STREAK_MAX) begin
      streak_inc = streak_q + SW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    rpt_d    = rpt_q;
    vld_d    = 1'b0;
    if (s1_valid_q) begin
      vld_d    = 1'b1;
      rpt_d    = '0;
      streak_d = growth ? streak_inc : '0;
      unique case (state_q)
        IDLE: begin
          if (btn_db) begin
            state_d     = BLOCKING;
            rpt_d.block = 1'b1;
            streak_d    = '0;
          end else if (streak_d == STREAK_MAX) begin
            state_d     = THRUSTING;
            rpt_d.lunge = 1'b1;
            tcnt_d      = '0;
            streak_d    = '0;
          end
        end
        BLOCKING: begin
          if (btn_db) begin
            rpt_d.block = 1'b1;
          end else begin
            state_d   = IDLE;
            rpt_d.rel = 1'b1;
          end
        end
        THRUSTING: begin
          if (retract || s1_lost_q || tcnt_q == THRUST_END) begin
            state_d   = IDLE;
            rpt_d.rel = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      streak_q <= '0;
      tcnt_q   <= '0;
      rpt_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
      rpt_q    <= rpt_d;
      vld_q    <= vld_d;
    end
  end

  assign block_out    = rpt_q.block;
  assign lunge_out    = rpt_q.lunge;
  assign release_out  = rpt_q.rel;
  assign ir_out_valid = vld_q;

endmodule

// File: tb/tb_saber_gesture_detector.sv
// Directed plus randomized bench for saber_gesture_detector.
// Reports are predicted by a flag-level gesture model and a queue.
module tb_saber_gesture_detector;

  localparam int DEB   = 4;
  localparam int DELTA = 16;
  localparam int FRAMES = 3;
  localparam int MAXT  = 5;
  localparam int MINA  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        sv;
  logic [10:0] x;
  logic [9:0]  y;
  logic [15:0] area_i;
  logic        blk, lng, rel, ovld;

  int total = 0;
  int bad   = 0;

  saber_gesture_detector #(
    .DEBOUNCE_CYCLES  (DEB),
    .LUNGE_AREA_DELTA (DELTA),
    .LUNGE_FRAMES     (FRAMES),
    .MAX_THRUST_FRAMES(MAXT),
    .MIN_AREA         (MINA)
  ) dut (
    .clk_pixel_in   (clk),
    .rst_n_in       (rst_n),
    .block_btn_in   (btn),
    .sample_valid_in(sv),
    .saber_x_in     (x),
    .saber_y_in     (y),
    .blob_area_in   (area_i),
    .block_out      (blk),
    .lunge_out      (lng),
    .release_out    (rel),
    .ir_out_valid   (ovld)
  );

  always #5 clk = ~clk;

  // Gesture model: flags for blocking / thrusting, frame counters
  int       m_prev;
  bit       m_prev_ok;
  int       m_streak;
  bit       m_blocking;
  bit       m_thrusting;
  int       m_frames;
  bit       btn_lvl;
  logic [2:0] exp_q[$];
  logic [2:0] last_rpt;
  logic [2:0] e;
  logic [1:0] sv_hist;

  function automatic void model_reset();
    m_prev      = 0;
    m_prev_ok   = 0;
    m_streak    = 0;
    m_blocking  = 0;
    m_thrusting = 0;
    m_frames    = 0;
    exp_q.delete();
    last_rpt    = 3'b000;
  endfunction

  function automatic logic [2:0] model_step(int area, bit b);
    bit         lost;
    int         d;
    logic [2:0] r;
    lost = area < MINA;
    d = (!m_prev_ok || lost) ? 0 : area - m_prev;
    m_prev    = area;
    m_prev_ok = !lost;
    if (d >= DELTA) m_streak = (m_streak < FRAMES) ? m_streak + 1 : FRAMES;
    else m_streak = 0;
    r = 3'b000;
    if (m_thrusting) begin
      if (d < 0 || lost || m_frames == MAXT - 1) begin
        m_thrusting = 0;
        r = 3'b001;
      end else begin
        m_frames++;
      end
    end else if (m_blocking) begin
      if (b) r = 3'b100;
      else begin
        m_blocking = 0;
        r = 3'b001;
      end
    end else if (b) begin
      m_blocking = 1;
      m_streak   = 0;
      r = 3'b100;
    end else if (m_streak == FRAMES) begin
      m_thrusting = 1;
      m_frames    = 0;
      m_streak    = 0;
      r = 3'b010;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sv_hist <= 2'b00;
    else sv_hist <= {sv_hist[0], sv};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (ovld === sv_hist[1]) else begin
        bad++;
        $error("FAIL valid_latency observed=%b expected=%b",
               ovld, sv_hist[1]);
      end
      if (ovld) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL extra_report observed=1 expected=0");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          last_rpt = e;
          total++;
          assert ({blk, lng, rel} === e) else begin
            bad++;
            $error("FAIL report observed=%b expected=%b",
                   {blk, lng, rel}, e);
          end
        end
      end else begin
        total++;
        assert ({blk, lng, rel} === last_rpt) else begin
          bad++;
          $error("FAIL hold observed=%b expected=%b",
                 {blk, lng, rel}, last_rpt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int area);
    sv     = 1'b1;
    area_i = 16'(area);
    x      = 11'($urandom);
    y      = 10'($urandom);
    exp_q.push_back(model_step(area, btn_lvl));
    tick(1);
    sv = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    total++;
    assert ({blk, lng, rel} === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b",
             tag, {blk, lng, rel}, exp);
    end
  endtask

  task automatic rpt(input int area, input logic [2:0] exp,
                     input string tag);
    send(area);
    tick(1);
    chk(tag, exp);
  endtask

  task automatic set_btn(input bit b);
    btn = b;
    tick(12);
    btn_lvl = b;
  endtask

  int a;
  int n;

  initial begin
    rst_n  = 1'b0;
    btn    = 1'b0;
    sv     = 1'b0;
    x      = '0;
    y      = '0;
    area_i = '0;
    btn_lvl = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 3'b000);
    total++;
    assert (ovld === 1'b0) else begin
      bad++;
      $error("FAIL reset_valid observed=%b expected=0", ovld);
    end
    rst_n = 1'b1;
    tick(2);

    // short button glitch must not register
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(10);
    rpt(100, 3'b000, "glitch_ignored");
    rpt(100, 3'b000, "glitch_no_state");

    set_btn(1);
    rpt(100, 3'b100, "block_enter");
    rpt(100, 3'b100, "block_hold");
    set_btn(0);
    rpt(100, 3'b001, "block_release");

    // lunge then retract
    rpt(100, 3'b000, "lunge_s1");
    rpt(120, 3'b000, "lunge_s2");
    rpt(140, 3'b000, "lunge_s3");
    rpt(160, 3'b010, "lunge_s4");
    rpt(150, 3'b001, "retract_release");
    rpt(150, 3'b000, "after_release");

    // button beats a simultaneous lunge trigger
    rpt(100, 3'b000, "prio_s1");
    rpt(116, 3'b000, "prio_s2");
    rpt(132, 3'b000, "prio_s3");
    set_btn(1);
    rpt(148, 3'b100, "prio_block");
    set_btn(0);
    rpt(148, 3'b001, "prio_release");

    // lost saber ends thrust, next sample has zero delta
    rpt(100, 3'b000, "lost_s1");
    rpt(120, 3'b000, "lost_s2");
    rpt(140, 3'b000, "lost_s3");
    rpt(160, 3'b010, "lost_lunge");
    rpt(4,   3'b001, "lost_release");
    rpt(200, 3'b000, "lost_zero_delta");
    rpt(220, 3'b000, "regrow_s1");

    // thrust force-released after MAXT samples
    rpt(240, 3'b000, "max_s2");
    rpt(260, 3'b010, "max_lunge");
    rpt(280, 3'b000, "max_t1");
    rpt(300, 3'b000, "max_t2");
    rpt(320, 3'b000, "max_t3");
    rpt(340, 3'b000, "max_t4");
    rpt(360, 3'b001, "max_release");

    // randomized back-to-back bursts
    for (int b = 0; b < 16; b++) begin
      if ($urandom_range(0, 3) == 0) set_btn(!btn_lvl);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 4))
          0, 1: a = m_prev + DELTA + int'($urandom_range(0, 30));
          2: a = int'($urandom_range(0, MINA - 1));
          3: a = m_prev - int'($urandom_range(1, 30));
          default: a = int'($urandom_range(0, 2000));
        endcase
        if (a < 0) a = 0;
        if (a > 65535) a = 65535;
        send(a);
      end
      tick(3);
    end

    // force IDLE, then async reset in BLOCKING
    set_btn(0);
    send(4);
    tick(3);
    set_btn(1);
    rpt(100, 3'b100, "pre_reset_block");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 3'b000);
    total++;
    assert (ovld === 1'b0) else begin
      bad++;
      $error("FAIL async_reset_valid observed=%b expected=0", ovld);
    end
    model_reset();
    btn = 1'b0;
    btn_lvl = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    rpt(100, 3'b000, "post_reset_no_release");
    tick(4);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL pending_reports observed=%0d expected=0",
             exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
